// File: rtl/o_user_encoder_gen.sv
// rtl/o_user_encoder_gen.sv - quadrature A/B/Z encoder emulator driven by step commands
// Optional macro ENC_ERR_INJ_EN adds I_INJ_ERR for illegal double-transition injection.
module o_user_encoder_gen #(
  parameter int CNT_W    = 32,
  parameter int DIV_W    = 16,
  parameter int PPR_QUAD = 4096
) (
  input  logic             I_CLK_100MHZ,
  input  logic             I_RST,
  input  logic             I_START,
  input  logic             I_DIR,
  input  logic [CNT_W-1:0] I_STEPS,
  input  logic [DIV_W-1:0] I_PERIOD,
  input  logic             I_STOP,
`ifdef ENC_ERR_INJ_EN
  input  logic             I_INJ_ERR,
`endif
  output logic             O_ENC_A,
  output logic             O_ENC_B,
  output logic             O_ENC_Z,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic [CNT_W-1:0] O_POS
);

  localparam int IDX_W = (PPR_QUAD > 1) ? $clog2(PPR_QUAD) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PPR_QUAD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t           state;
  logic [1:0]       phase;
  logic [IDX_W-1:0] r_idx;
  logic [DIV_W-1:0] timer;
  logic [DIV_W-1:0] period;
  logic [CNT_W-1:0] remaining;
  logic             dir;
  logic             err_flag;

  logic             expire;
  logic             err_use;
  logic [1:0]       ph_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic [CNT_W-1:0] pos_nxt;

  // Next-edge values; an injected error jumps two phases and freezes position/index.
  always_comb begin
    expire  = (state == RUN) && (timer == period - DIV_W'(1));
`ifdef ENC_ERR_INJ_EN
    err_use = err_flag | I_INJ_ERR;
`else
    err_use = 1'b0;
`endif
    ph_nxt  = dir ? (phase - 2'd1) : (phase + 2'd1);
    pos_nxt = dir ? (O_POS - CNT_W'(1)) : (O_POS + CNT_W'(1));
    if (dir) begin
      idx_nxt = (r_idx == '0) ? IDX_MAX : (r_idx - IDX_W'(1));
    end else begin
      idx_nxt = (r_idx == IDX_MAX) ? '0 : (r_idx + IDX_W'(1));
    end
    if (err_use) begin
      ph_nxt  = phase + 2'd2;
      pos_nxt = O_POS;
      idx_nxt = r_idx;
    end
  end

  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      state     <= IDLE;
      phase     <= 2'd0;
      r_idx     <= '0;
      timer     <= '0;
      period    <= DIV_W'(1);
      remaining <= '0;
      dir       <= 1'b0;
      err_flag  <= 1'b0;
      O_ENC_A   <= 1'b0;
      O_ENC_B   <= 1'b0;
      O_ENC_Z   <= 1'b1;
      O_BUSY    <= 1'b0;
      O_DONE    <= 1'b0;
      O_POS     <= '0;
    end else begin
      case (state)
        IDLE: begin
          O_DONE   <= 1'b0;
          err_flag <= 1'b0;
          if (I_START) begin
            dir       <= I_DIR;
            remaining <= I_STEPS;
            period    <= (I_PERIOD == '0) ? DIV_W'(1) : I_PERIOD;
            state     <= LOAD;
            O_BUSY    <= 1'b1;
          end
        end
        LOAD: begin
          timer <= '0;
          if (remaining == '0 || I_STOP) begin
            state  <= DONE;
            O_DONE <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: begin
`ifdef ENC_ERR_INJ_EN
          if (I_INJ_ERR) err_flag <= 1'b1;
`endif
          if (expire) begin
            timer     <= '0;
            phase     <= ph_nxt;
            O_ENC_A   <= ph_nxt[1] ^ ph_nxt[0];
            O_ENC_B   <= ph_nxt[1];
            r_idx     <= idx_nxt;
            O_ENC_Z   <= (idx_nxt == '0);
            O_POS     <= pos_nxt;
            remaining <= remaining - CNT_W'(1);
            if (err_use) err_flag <= 1'b0;
            // The edge due this cycle is emitted even when a stop arrives with it.
            if (remaining == CNT_W'(1) || I_STOP) begin
              state  <= DONE;
              O_DONE <= 1'b1;
            end
          end else begin
            timer <= timer + DIV_W'(1);
            if (I_STOP) begin
              state  <= DONE;
              O_DONE <= 1'b1;
            end
          end
        end
        DONE: begin
          O_DONE <= 1'b0;
          O_BUSY <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_o_user_encoder_gen.sv
// tb/tb_o_user_encoder_gen.sv - randomized self-checking bench for o_user_encoder_gen
module tb_o_user_encoder_gen;

  localparam int CNT_W = 32;
  localparam int DIV_W = 16;
  localparam int PPR   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             dir_in;
  logic [CNT_W-1:0] steps_in;
  logic [DIV_W-1:0] period_in;
  logic             stop;
  logic             enc_a, enc_b, enc_z, busy, done;
  logic [CNT_W-1:0] pos;
`ifdef ENC_ERR_INJ_EN
  logic             inj = 1'b0;
`endif

  always #5 clk = ~clk;

  o_user_encoder_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W), .PPR_QUAD(PPR)) dut (
    .I_CLK_100MHZ(clk),
    .I_RST       (rst),
    .I_START     (start),
    .I_DIR       (dir_in),
    .I_STEPS     (steps_in),
    .I_PERIOD    (period_in),
    .I_STOP      (stop),
`ifdef ENC_ERR_INJ_EN
    .I_INJ_ERR   (inj),
`endif
    .O_ENC_A     (enc_a),
    .O_ENC_B     (enc_b),
    .O_ENC_Z     (enc_z),
    .O_BUSY      (busy),
    .O_DONE      (done),
    .O_POS       (pos)
  );

  int     total = 0;
  int     bad   = 0;
  longint mpos  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Outputs as a function of absolute position: phase = pos mod 4, Z = (pos mod PPR == 0).
  task automatic check_outputs(input longint p, input logic b, input logic d);
    logic [1:0]       m;
    logic [1:0]       ab;
    logic [CNT_W-1:0] pw;
    m  = p[1:0];
    pw = p[CNT_W-1:0];
    case (m)
      2'd0:    ab = 2'b00;
      2'd1:    ab = 2'b10;
      2'd2:    ab = 2'b11;
      default: ab = 2'b01;
    endcase
    check("pos",  pos, pw);
    check("ab",   {enc_a, enc_b}, ab);
    check("z",    enc_z, (((p % PPR) + PPR) % PPR) == 0);
    check("busy", busy, b);
    check("done", done, d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    #1;
    mpos = 0;
    check_outputs(0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_outputs(0, 1'b0, 1'b0);
  endtask

  // stop_at < 0: no stop; 0: stop together with start; >=1: stop in that cycle.
  task automatic run_cmd(input logic d_in, input int n, input int per, input int stop_at);
    int p, e, dc, vis, ek;
    p  = (per == 0) ? 1 : per;
    e  = n;
    dc = 2 + n * p;
    if (stop_at >= 1) begin
      ek = (stop_at - 1) / p;
      if (ek < n) begin
        e  = ek;
        dc = stop_at + 1;
      end
    end
    @(negedge clk);
    start = 1'b1; dir_in = d_in; steps_in = CNT_W'(n); period_in = DIV_W'(per);
    stop = (stop_at == 0);
    for (int t = 1; t <= dc + 1; t++) begin
      @(negedge clk);
      stop = (t == stop_at);
      if (t <= dc && $urandom_range(0, 3) == 0) begin
        start = 1'b1; dir_in = 1'($urandom);
        steps_in = CNT_W'($urandom_range(0, 50)); period_in = DIV_W'($urandom);
      end else begin
        start = 1'b0;
      end
      vis = (t < 2) ? 0 : (t - 2) / p;
      if (vis > e) vis = e;
      check_outputs(mpos + (d_in ? -vis : vis), t <= dc, t == dc);
    end
    stop = 1'b0;
    mpos += d_in ? -e : e;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir_in = 1'b0; steps_in = '0; period_in = '0; stop = 1'b0;

    do_reset();
    run_cmd(1'b0, 8, 4, -1);
    check("cw8_pos", pos, 64'd8);

    do_reset();
    run_cmd(1'b1, 4, 1, -1);
    check("ccw4_pos", pos, 64'hFFFF_FFFC);

    do_reset();
    run_cmd(1'b0, 16, 2, -1);
    check("cw16_z", enc_z, 1'b1);
    run_cmd(1'b1, 1, 3, -1);
    check("ccw1_pos", pos, 64'd15);
    check("ccw1_z", enc_z, 1'b0);

    run_cmd(1'b0, 0, 3, -1);
    run_cmd(1'b0, 5, 0, -1);
    run_cmd(1'b1, 3, 1, 0);
    mpos = pos;
    do_reset();
    run_cmd(1'b0, 100, 10, 55);
    check("stop_pos", pos, 64'd5);

    // Reset in the middle of a run discards it without a completion pulse.
    @(negedge clk);
    start = 1'b1; dir_in = 1'b0; steps_in = CNT_W'(50); period_in = DIV_W'(3);
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      int n, per, sa;
      n   = $urandom_range(0, 20);
      per = $urandom_range(0, 5);
      sa  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 + n * ((per == 0) ? 1 : per)) : -1;
      run_cmd(1'($urandom), n, per, sa);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        stop = 1'($urandom);
        check_outputs(mpos, 1'b0, 1'b0);
      end
      stop = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
